mod_cipher_stream: RTL and testbench
====================================

# mod_cipher_stream

Streaming, parametrised modular character cipher engine for the crypto datapath. A configuration handshake loads a key and mode; each accepted character is then encrypted, C = (P + K) mod MODULUS, or decrypted, P = (C − K) mod MODULUS, through a 2-stage pipeline with full valid/ready backpressure. Invalid characters produce a NULL output flagged with a per-beat error. Saturating counters report processed and rejected characters. The block sits between the character source and the ciphertext/plaintext sink.

## Interface
- DATA_W, 8, character/key width.
- MODULUS, 227, prime modulus; elaboration error if MODULUS ≥ 2^DATA_W or MODULUS < 2.
- CHAR_MIN, 8'h61, lowest legal plaintext in encrypt mode.
- CHAR_MAX, 8'h7A, highest legal plaintext; elaboration error if CHAR_MAX ≥ MODULUS or CHAR_MIN > CHAR_MAX.
- CNT_W, 16, counter width.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accepted this cycle when high with cfg_valid.
- cfg_mode  in  2  2'b01 encrypt, 2'b10 decrypt, others illegal.
- cfg_key  in  DATA_W  key; legal when < MODULUS.
- cfg_err  out  1  one-cycle pulse: rejected configuration.
- in_valid / in_ready  in / out  1 / 1  input character handshake.
- in_data  in  DATA_W  input character.
- out_valid / out_ready  out / in  1 / 1  output handshake.
- out_data  out  DATA_W  result; 8'h00 (NULL) when out_err.
- out_err  out  1  input character invalid for current mode.
- char_cnt  out  CNT_W  accepted characters, saturating.
- err_cnt  out  CNT_W  characters flagged out_err, saturating.

## Operation
- FSM states: IDLE (no valid key), RUN, DRAIN.
- IDLE: in_ready=0; cfg_ready=1. Legal cfg accepted → latch mode/key, clear both counters, → RUN. Illegal cfg (mode 00/11 or key ≥ MODULUS) → cfg_err pulse, stay IDLE; previous key not retained.
- RUN: in_ready = pipeline can advance. cfg_valid high → DRAIN (cfg_ready=0 unless pipeline already empty, in which case accept directly as in IDLE).
- DRAIN: in_ready=0; wait until both stages empty, then cfg_ready=1; accept → RUN (legal) or IDLE with cfg_err (illegal).
- Validity: encrypt requires CHAR_MIN ≤ in_data ≤ CHAR_MAX; decrypt requires in_data < MODULUS.
- Arithmetic in DATA_W+1 bits. Stage 1: encrypt s = in + K; decrypt s = in − K (borrow kept in MSB), plus validity bit. Stage 2: encrypt: if s ≥ MODULUS then s − MODULUS. Decrypt: if borrow then s + MODULUS. Truncate to DATA_W.
- Invalid beat: still traverses the pipeline in order; out_data=8'h00, out_err=1.
- char_cnt increments on every in handshake; err_cnt on every invalid in handshake; both hold at 2^CNT_W−1.

## Timing
- Reset values: cfg_ready=0 during reset, 1 the cycle after (IDLE); in_ready=0, out_valid=0, out_data=8'h00, out_err=0, cfg_err=0, counters 0, state IDLE, both stage valids 0.
- Latency: in handshake cycle N → out_valid at N+2 with out_ready high; throughput 1/cycle.
- Stall-all pipeline: advance = !out_valid || out_ready; in_ready = (state==RUN) && advance && !cfg_valid.
- out_data/out_err stable while out_valid && !out_ready; no beat dropped or duplicated.
- cfg_valid and in_valid in the same RUN cycle: cfg wins; the char is not accepted.
- Reset mid-stream: all in-flight beats discarded, key invalidated.

## Structure
- Package mod_cipher_pkg: mode enum (MODE_ENC=2'b01, MODE_DEC=2'b10), state enum, NULL_CHAR=8'h00.
- Sub-module mod_reduce_stage (stage-2 conditional ±MODULUS, registered with valid/stall) instantiated once.

## Test plan
- Cfg enc key 5; send 'a' (0x61) → out_data 0x66, out_err 0, latency 2.
- Cfg enc key 200; send 'z' (0x7A) → 322−227 = 95 → 0x5F.
- Cfg dec key 10; send 0x05 → −5+227 = 222 → 0xDE; send 0xE3 (227) → out 0x00, out_err 1, err_cnt 1.
- Cfg key 230 or mode 2'b11 → cfg_err pulse, stays IDLE, in_ready 0.
- Stream 6 chars, hold out_ready low 3 cycles mid-stream → in_ready drops after 2 beats buffered, all 6 outputs in order, char_cnt 6.
- Reconfigure mid-stream → DRAIN until empty, then counters cleared; assert rst_n low mid-stream → all outputs at reset values next cycle.

Source files
------------

// File: rtl/mod_cipher_pkg.sv
// Shared types and constants for the modular character cipher stream.
package mod_cipher_pkg;

    typedef enum logic [1:0] {
        MODE_ENC = 2'b01,
        MODE_DEC = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [7:0] NULL_CHAR = 8'h00;

endpackage

// File: rtl/mod_reduce_stage.sv
// Second pipeline stage: folds the stage-1 sum/difference back into [0, MODULUS).
module mod_reduce_stage
    import mod_cipher_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MODULUS = 227
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              in_valid,
    input  logic [DATA_W:0]   in_sum,
    input  logic              in_ok,
    input  logic              in_dec,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    localparam logic [DATA_W:0] MOD_X = (DATA_W + 1)'(MODULUS);

    // Output register; holds its beat while the sink stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (advance) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_err <= !in_ok;
                if (!in_ok) begin
                    out_data <= DATA_W'(NULL_CHAR);
                end else if (in_dec) begin
                    // MSB set means the subtraction borrowed
                    out_data <= in_sum[DATA_W] ? DATA_W'(in_sum + MOD_X) : DATA_W'(in_sum);
                end else begin
                    out_data <= (in_sum >= MOD_X) ? DATA_W'(in_sum - MOD_X) : DATA_W'(in_sum);
                end
            end
        end
    end

endmodule

// File: rtl/mod_cipher_stream.sv
// Streaming modular character cipher: config handshake, 2-stage pipeline, counters.
module mod_cipher_stream
    import mod_cipher_pkg::*;
#(
    parameter int unsigned        DATA_W   = 8,
    parameter int unsigned        MODULUS  = 227,
    parameter logic [DATA_W-1:0]  CHAR_MIN = 8'h61,
    parameter logic [DATA_W-1:0]  CHAR_MAX = 8'h7A,
    parameter int unsigned        CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W-1:0] cfg_key,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  char_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [DATA_W-1:0] KEY_LIM = DATA_W'(MODULUS);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    if ((MODULUS >> DATA_W) != 0 || MODULUS < 2) begin : g_bad_modulus
        $error("MODULUS must satisfy 2 <= MODULUS < 2**DATA_W");
    end
    if (CHAR_MAX >= MODULUS || CHAR_MIN > CHAR_MAX) begin : g_bad_range
        $error("Character range must satisfy CHAR_MIN <= CHAR_MAX < MODULUS");
    end

    state_e            state;
    mode_e             mode;
    logic [DATA_W-1:0] key;
    logic              s1_valid;
    logic              s1_ok;
    logic              s1_dec;
    logic [DATA_W:0]   s1_sum;
    logic              advance;
    logic              pipe_empty;
    logic              cfg_hs;
    logic              in_hs;
    logic              cfg_legal;
    logic              in_ok;
    logic [DATA_W:0]   sum_c;

    // Stall-all pipeline control and handshakes; a pending cfg blocks new characters.
    assign advance    = !out_valid || out_ready;
    assign pipe_empty = !s1_valid && !out_valid;
    assign cfg_ready  = rst_n && (state == ST_IDLE || pipe_empty);
    assign in_ready   = rst_n && (state == ST_RUN) && advance && !cfg_valid;
    assign cfg_hs     = cfg_valid && cfg_ready;
    assign in_hs      = in_valid && in_ready;
    assign cfg_legal  = (cfg_mode == MODE_ENC || cfg_mode == MODE_DEC) && (cfg_key < KEY_LIM);

    // Character legality and raw stage-1 arithmetic (one extra bit for carry/borrow).
    assign in_ok = (mode == MODE_ENC) ? (in_data >= CHAR_MIN && in_data <= CHAR_MAX)
                                      : (in_data < KEY_LIM);
    assign sum_c = (mode == MODE_ENC) ? ({1'b0, in_data} + {1'b0, key})
                                      : ({1'b0, in_data} - {1'b0, key});

    // Control FSM: key/mode load, drain on reconfiguration, reject pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mode    <= MODE_ENC;
            key     <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (cfg_hs) begin
                if (cfg_legal) begin
                    state <= ST_RUN;
                    mode  <= mode_e'(cfg_mode);
                    key   <= cfg_key;
                end else begin
                    state   <= ST_IDLE;
                    key     <= '0;
                    cfg_err <= 1'b1;
                end
            end else if (state == ST_RUN && cfg_valid) begin
                state <= ST_DRAIN;
            end
        end
    end

    // Stage 1: capture raw sum/difference and validity of the accepted character.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_ok    <= 1'b0;
            s1_dec   <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_hs;
            if (in_hs) begin
                s1_sum <= sum_c;
                s1_ok  <= in_ok;
                s1_dec <= (mode == MODE_DEC);
            end
        end
    end

    // Saturating character and error counters, cleared by each accepted key.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            char_cnt <= '0;
            err_cnt  <= '0;
        end else if (cfg_hs && cfg_legal) begin
            char_cnt <= '0;
            err_cnt  <= '0;
        end else if (in_hs) begin
            if (char_cnt != CNT_MAX) char_cnt <= char_cnt + 1'b1;
            if (!in_ok && err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        end
    end

    mod_reduce_stage #(
        .DATA_W  (DATA_W),
        .MODULUS (MODULUS)
    ) u_reduce (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (advance),
        .in_valid  (s1_valid),
        .in_sum    (s1_sum),
        .in_ok     (s1_ok),
        .in_dec    (s1_dec),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_err   (out_err)
    );

endmodule

// File: tb/tb_mod_cipher_stream.sv
// Bench for mod_cipher_stream: vector table, scoreboard queue, hand-written corner sequences.
module tb_mod_cipher_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_ready, cfg_err;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_key;
    logic        in_valid, in_ready;
    logic [7:0]  in_data;
    logic        out_valid, out_ready, out_err;
    logic [7:0]  out_data;
    logic [15:0] char_cnt, err_cnt;

    mod_cipher_stream dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
        .cfg_key(cfg_key), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .char_cnt(char_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] key;
        logic [7:0] ch;
        logic [7:0] exp_d;
        logic       exp_e;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         c;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    bit         chk_lat = 1'b0;
    logic [1:0] b_mode = 2'b01;
    int         b_key = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: plain integer modular arithmetic.
    function automatic logic [8:0] model(input logic [1:0] md, input int k, input int ch);
        int r;
        if (md == 2'b01) begin
            if (ch < 97 || ch > 122) return {1'b1, 8'h00};
            r = (ch + k) % 227;
        end else begin
            if (ch >= 227) return {1'b1, 8'h00};
            r = (((ch - k) % 227) + 227) % 227;
        end
        return {1'b0, 8'(r)};
    endfunction

    // Scoreboard consumer: pop and compare on every output handshake.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            q.delete();
        end else if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("out_data", 32'(out_data), 32'(e.d));
                check("out_err", 32'(out_err), 32'(e.e));
                if (chk_lat) check("latency", 32'(cyc - e.c), 32'd2);
            end
        end
    end

    // Drive one character (starting just after a rising edge), push expectation on handshake.
    task automatic send(input logic [7:0] ch, input logic [7:0] ed, input logic ee);
        exp_t e;
        int   n = 0;
        in_valid = 1'b1;
        in_data  = ch;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_timeout", 32'(in_ready), 32'd1);
        end else begin
            e.d = ed; e.e = ee; e.c = cyc;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [7:0] ch);
        logic [8:0] r;
        r = model(b_mode, b_key, int'(ch));
        send(ch, r[7:0], r[8]);
    endtask

    task automatic do_cfg(input logic [1:0] md, input logic [7:0] k, input logic exp_err);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_mode  = md;
        cfg_key   = k;
        @(negedge clk);
        while (!cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cfg_timeout", 32'(cfg_ready), 32'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        check("cfg_err", 32'(cfg_err), 32'(exp_err));
        if (!exp_err) begin
            b_mode = md;
            b_key  = int'(k);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        vecs[0] = '{2'b01, 8'd5,   8'h61, 8'h66, 1'b0};
        vecs[1] = '{2'b01, 8'd200, 8'h7A, 8'h5F, 1'b0};
        vecs[2] = '{2'b10, 8'd10,  8'h05, 8'hDE, 1'b0};
        vecs[3] = '{2'b10, 8'd10,  8'hE3, 8'h00, 1'b1};
        vecs[4] = '{2'b01, 8'd0,   8'h60, 8'h00, 1'b1};
        vecs[5] = '{2'b01, 8'd0,   8'h7B, 8'h00, 1'b1};
        vecs[6] = '{2'b10, 8'd226, 8'hE2, 8'h00, 1'b0};
        vecs[7] = '{2'b01, 8'd226, 8'h61, 8'h60, 1'b0};
        vecs[8] = '{2'b10, 8'd0,   8'h00, 8'h00, 1'b0};
        vecs[9] = '{2'b01, 8'd22,  8'h7A, 8'h90, 1'b0};

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_key = 8'h00;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_char_cnt", 32'(char_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cfg_ready", 32'(cfg_ready), 32'd1);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;

        // Vector table: one configuration and one character each
        chk_lat = 1'b1;
        foreach (vecs[i]) begin
            do_cfg(vecs[i].mode, vecs[i].key, 1'b0);
            send(vecs[i].ch, vecs[i].exp_d, vecs[i].exp_e);
            wait_drain();
            @(negedge clk);
            check($sformatf("vec%0d_char_cnt", i), 32'(char_cnt), 32'd1);
            check($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_e));
            @(posedge clk); #1;
        end
        chk_lat = 1'b0;

        // Illegal configurations
        do_cfg(2'b01, 8'd230, 1'b1);
        @(negedge clk);
        check("cfg_err_pulse_end", 32'(cfg_err), 32'd0);
        check("bad_key_cfg_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk); #1;
        do_cfg(2'b11, 8'd5, 1'b1);
        in_valid = 1'b1; in_data = 8'h61;
        @(negedge clk);
        check("bad_mode_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Stream of 6 with a 3-cycle sink stall
        do_cfg(2'b01, 8'd3, 1'b0);
        fork
            begin
                send_m(8'h61); send_m(8'h62); send_m(8'h40);
                send_m(8'h78); send_m(8'h79); send_m(8'h7A);
            end
            begin
                repeat (2) @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        @(negedge clk);
        check("stream_char_cnt", 32'(char_cnt), 32'd6);
        check("stream_err_cnt", 32'(err_cnt), 32'd1);
        @(posedge clk); #1;

        // Reconfigure with a full, stalled pipeline
        do_cfg(2'b01, 8'd1, 1'b0);
        out_ready = 1'b0;
        send_m(8'h63);
        send_m(8'h64);
        cfg_valid = 1'b1; cfg_mode = 2'b10; cfg_key = 8'd2;
        @(negedge clk);
        check("run_cfg_ready", 32'(cfg_ready), 32'd0);
        check("run_cfg_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_cfg_ready", 32'(cfg_ready), 32'd0);
        check("drain_out_data", 32'(out_data), 32'h64);
        @(posedge clk); #1;
        out_ready = 1'b1;
        do_cfg(2'b10, 8'd2, 1'b0);
        @(negedge clk);
        check("recfg_char_cnt", 32'(char_cnt), 32'd0);
        check("recfg_err_cnt", 32'(err_cnt), 32'd0);
        check("recfg_q_empty", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
        send_m(8'h01);
        wait_drain();

        // Reset mid-stream
        out_ready = 1'b0;
        send_m(8'h03);
        send_m(8'h04);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_out_err", 32'(out_err), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("mid_rst_char_cnt", 32'(char_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("post_rst_in_ready", 32'(in_ready), 32'd0);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
